// File: rtl/pll_seq_pkg.sv
// Shared types and default timing for the pixel-clock PLL reset sequencer.
// Defaults assume a 12 MHz reference clock.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RST,
    ST_WAIT_LOCK,
    ST_STABLE,
    ST_RUN,
    ST_FAULT
  } state_t;

  localparam int DEF_PLL_RESET_CYCLES    = 12;     // 1 us
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 12000;  // 1 ms
  localparam int DEF_LOCK_STABLE_CYCLES  = 1200;   // 100 us
  localparam int DEF_MAX_RETRIES         = 3;

  // Counter only needs to reach (largest cycle count - 1).
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous status bit; clears to 0 on reset.
module sync_2ff (
  input  logic gclk,
  input  logic grst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL power-up/recovery sequencer: pulses RESETB, qualifies LOCK, releases the PLL domain.
// Define PLL_SEQ_LOCK_RECOVERY_EN to restart the sequence when lock is lost in RUN.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int PLL_RESET_CYCLES    = DEF_PLL_RESET_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int MAX_RETRIES         = DEF_MAX_RETRIES,
  localparam int RC_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
  input  logic            REFERENCECLK,
  input  logic            RESET,
  input  logic            PLL_LOCK,
  output logic            PLL_RESETB,
  output logic            DOMAIN_RESET,
  output logic            READY,
  output logic            FAULT,
  output logic [RC_W-1:0] RETRY_COUNT
);

  localparam int CW = cnt_width(PLL_RESET_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES);
  localparam logic [CW-1:0]   RST_LAST = CW'(PLL_RESET_CYCLES - 1);
  localparam logic [CW-1:0]   TMO_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0]   STB_LAST = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RC_W-1:0] RC_MAX   = RC_W'(MAX_RETRIES);

  state_t        state, nxt;
  logic [CW-1:0] cnt;
  logic          lock_s;
  logic          fail;
  logic          clr_retry;

  sync_2ff u_lock_sync (
    .gclk  (REFERENCECLK),
    .grst_n(RESET),
    .d     (PLL_LOCK),
    .q     (lock_s)
  );

  always_comb begin
    nxt       = state;
    fail      = 1'b0;
    clr_retry = 1'b0;
    case (state)
      ST_PLL_RST:   if (cnt == RST_LAST) nxt = ST_WAIT_LOCK;
      // Lock takes priority over a coincident timeout.
      ST_WAIT_LOCK: if (lock_s) nxt = ST_STABLE;
                    else if (cnt == TMO_LAST) fail = 1'b1;
      ST_STABLE:    if (!lock_s) fail = 1'b1;
                    else if (cnt == STB_LAST) nxt = ST_RUN;
      ST_RUN: begin
`ifdef PLL_SEQ_LOCK_RECOVERY_EN
        if (!lock_s) begin
          nxt       = ST_PLL_RST;
          clr_retry = 1'b1;
        end
`endif
      end
      default: ;
    endcase
    if (fail) nxt = (RETRY_COUNT == RC_MAX) ? ST_FAULT : ST_PLL_RST;
  end

  // Outputs decode the next state so they switch on the same edge as the state.
  always_ff @(posedge REFERENCECLK or negedge RESET) begin
    if (!RESET) begin
      state        <= ST_PLL_RST;
      cnt          <= '0;
      RETRY_COUNT  <= '0;
      PLL_RESETB   <= 1'b0;
      DOMAIN_RESET <= 1'b0;
      READY        <= 1'b0;
      FAULT        <= 1'b0;
    end else begin
      state <= nxt;
      if (nxt != state)
        cnt <= '0;
      else if (state inside {ST_PLL_RST, ST_WAIT_LOCK, ST_STABLE})
        cnt <= cnt + 1'b1;
      if (clr_retry)
        RETRY_COUNT <= '0;
      else if (fail && (RETRY_COUNT != RC_MAX))
        RETRY_COUNT <= RETRY_COUNT + RC_W'(1);
      PLL_RESETB   <= (nxt == ST_WAIT_LOCK) || (nxt == ST_STABLE) || (nxt == ST_RUN);
      DOMAIN_RESET <= (nxt == ST_RUN);
      READY        <= (nxt == ST_RUN);
      FAULT        <= (nxt == ST_FAULT);
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer (default parameters); expected outputs are queued
// by cycle and a negedge monitor compares {PLL_RESETB,DOMAIN_RESET,READY,FAULT,RETRY_COUNT}.
module tb_pll_reset_sequencer;

  logic       clk = 1'b0;
  logic       RESET;
  logic       PLL_LOCK;
  logic       PLL_RESETB, DOMAIN_RESET, READY, FAULT;
  logic [1:0] RETRY_COUNT;
  logic [5:0] obs;

  int    cyc = 0;
  int    n_vec = 0;
  int    n_err = 0;
  int    due_q[$];
  logic [5:0] v_q[$];
  string tag_q[$];

  localparam int PERIOD_RETRY = 12012;

  pll_reset_sequencer dut (
    .REFERENCECLK(clk),
    .RESET       (RESET),
    .PLL_LOCK    (PLL_LOCK),
    .PLL_RESETB  (PLL_RESETB),
    .DOMAIN_RESET(DOMAIN_RESET),
    .READY       (READY),
    .FAULT       (FAULT),
    .RETRY_COUNT (RETRY_COUNT)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign obs = {PLL_RESETB, DOMAIN_RESET, READY, FAULT, RETRY_COUNT};

  // Scoreboard insert, kept sorted by due cycle.
  task automatic expect_abs(input int due, input string tag, input logic [5:0] v);
    int i = 0;
    while (i < due_q.size() && due_q[i] <= due) i++;
    due_q.insert(i, due);
    v_q.insert(i, v);
    tag_q.insert(i, tag);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // PLL_RST entered with counter 0 visible at cycle s: low through s+11, high at s+12.
  task automatic pulse_checks(input int s, input logic [1:0] rc);
    expect_abs(s + 1,  "rstb_lo_first", {4'b0000, rc});
    expect_abs(s + 11, "rstb_lo_last",  {4'b0000, rc});
    expect_abs(s + 12, "rstb_hi",       {4'b1000, rc});
  endtask

  task automatic apply_reset(input string tag, output int r);
    @(posedge clk);
    #1;
    RESET    = 1'b0;
    PLL_LOCK = 1'b0;
    expect_abs(cyc, tag, 6'b000000);
    @(negedge clk);
    @(negedge clk);
    RESET = 1'b1;
    r = cyc;
  endtask

  always @(negedge clk) begin
    while (due_q.size() > 0 && due_q[0] <= cyc) begin
      n_vec++;
      if (due_q[0] < cyc) begin
        n_err++;
        $display("FAIL %s: slot %0d missed (now %0d)", tag_q[0], due_q[0], cyc);
      end else if (obs !== v_q[0]) begin
        n_err++;
        $display("FAIL %s @cyc %0d: got %b want %b", tag_q[0], cyc, obs, v_q[0]);
      end
      void'(due_q.pop_front());
      void'(v_q.pop_front());
      void'(tag_q.pop_front());
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: stimulus did not complete");
    $fatal(1);
  end

  initial begin
    int r, w, e0, d, g, f, s;
    RESET    = 1'b0;
    PLL_LOCK = 1'b0;

    // Reset values, then clean lock 8 cycles after RESETB release.
    wait_until(2);
    expect_abs(3, "in_reset", 6'b000000);
    wait_until(4);
    RESET = 1'b1;
    r = cyc;
    pulse_checks(r, 2'd0);
    w = r + 12;
    wait_until(w + 7);
    PLL_LOCK = 1'b1;
    e0 = w + 8;
    expect_abs(e0 + 1201, "pre_run", 6'b100000);
    expect_abs(e0 + 1202, "run",     6'b111000);

    // Lock drop while in RUN.
    wait_until(e0 + 1208);
    PLL_LOCK = 1'b0;
    d = e0 + 1209;
    expect_abs(d + 1, "run_hold", 6'b111000);
`ifdef PLL_SEQ_LOCK_RECOVERY_EN
    expect_abs(d + 2, "recover",      6'b000000);
    expect_abs(d + 4, "recover_hold", 6'b000000);
`else
    expect_abs(d + 2, "run_ignore",      6'b111000);
    expect_abs(d + 6, "run_ignore_hold", 6'b111000);
`endif
    wait_until(d + 8);

    // 3-cycle lock glitch 500 cycles into STABLE, then clean lock.
    apply_reset("rst_in_run", r);
    pulse_checks(r, 2'd0);
    w = r + 12;
    wait_until(w + 7);
    PLL_LOCK = 1'b1;
    e0 = w + 8;
    g = e0 + 502;
    f = g + 2;
    wait_until(g - 1);
    PLL_LOCK = 1'b0;
    expect_abs(g + 1, "stable_hold", 6'b100000);
    expect_abs(f,     "glitch_fail", 6'b000001);
    pulse_checks(f, 2'd1);
    expect_abs(f + 1212, "pre_run2",         6'b100001);
    expect_abs(f + 1213, "run_after_glitch", 6'b111001);
    wait_until(g + 2);
    PLL_LOCK = 1'b1;
    wait_until(f + 1215);

    // lock_s rises exactly when the timeout counter reads 11999.
    apply_reset("rst_after_glitch", r);
    pulse_checks(r, 2'd0);
    w = r + 12;
    wait_until(w + 11997);
    PLL_LOCK = 1'b1;
    expect_abs(w + 11999, "wait_last",       6'b100000);
    expect_abs(w + 12000, "lock_at_timeout", 6'b100000);
    expect_abs(w + 12013, "stable_no_retry", 6'b100000);
    wait_until(w + 12100);

    // Mid-STABLE reset, then never lock: four attempts and FAULT.
    apply_reset("rst_mid_stable", r);
    for (int i = 0; i < 4; i++) begin
      s = r + i * PERIOD_RETRY;
      if (i > 0) expect_abs(s, "retry_step", {4'b0000, 2'(i)});
      pulse_checks(s, 2'(i));
      expect_abs(s + 12011, "pre_timeout", {4'b1000, 2'(i)});
    end
    f = r + 4 * PERIOD_RETRY;
    expect_abs(f,      "fault",      6'b000111);
    expect_abs(f + 20, "fault_hold", 6'b000111);
    wait_until(f + 30);

    // Mid-FAULT reset restarts with a fresh 12-cycle pulse.
    apply_reset("rst_mid_fault", r);
    pulse_checks(r, 2'd0);
    wait_until(r + 20);
    @(negedge clk);

    while (due_q.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: slot %0d never reached (now %0d)", tag_q[0], due_q[0], cyc);
      void'(due_q.pop_front());
      void'(v_q.pop_front());
      void'(tag_q.pop_front());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pll_reset_sequencer.md
# pll_reset_sequencer

Power-up and recovery sequencer for the pixel-clock PLL. It pulses the PLL's active-low RESETB, waits for LOCK and qualifies it as stable, then releases an active-low reset to the logic clocked by the PLL output. It retries on timeout, stops in a fault state after repeated failures, and runs entirely on the PLL's reference clock (12 MHz board oscillator). It sits between the board-level reset and the PLL instance plus its downstream domain.

## Interface
Parameters:
- PLL_RESET_CYCLES, 12: cycles PLL_RESETB is held low per attempt (1 µs at 12 MHz); minimum 1.
- LOCK_TIMEOUT_CYCLES, 12000: cycles allowed in WAIT_LOCK before the attempt fails (1 ms).
- LOCK_STABLE_CYCLES, 1200: consecutive synchronized-lock cycles required before release (100 µs); minimum 1.
- MAX_RETRIES, 3: failed attempts tolerated before FAULT; 0 means the first failure faults.

Ports:
- REFERENCECLK  in  1  the only clock; PLL reference clock.
- RESET  in  1  asynchronous, active-low; clears every register.
- PLL_LOCK  in  1  PLL LOCK output; asynchronous to REFERENCECLK.
- PLL_RESETB  out  1  to the PLL RESETB pin; active-low.
- DOMAIN_RESET  out  1  active-low reset for the PLL-clocked domain; the consumer re-synchronizes its deassertion.
- READY  out  1  high only in RUN.
- FAULT  out  1  high only in FAULT.
- RETRY_COUNT  out  $clog2(MAX_RETRIES+1) (min 1)  number of failed attempts since the last RESET or recovery.

## Operation
- PLL_LOCK passes through a 2-flop synchronizer to produce lock_s.
- One shared cycle counter. Its width covers the largest of the three cycle parameters. It clears on every state change.
- State machine (states: PLL_RST, WAIT_LOCK, STABLE, RUN, FAULT):
  - PLL_RST: PLL_RESETB=0. When counter == PLL_RESET_CYCLES-1, go to WAIT_LOCK.
  - WAIT_LOCK: PLL_RESETB=1.
    - lock_s=1 → STABLE.
    - Otherwise, when counter == LOCK_TIMEOUT_CYCLES-1, the attempt fails.
    - If lock_s=1 and the timeout occur in the same cycle, lock wins.
  - STABLE:
    - lock_s=0 → the attempt fails.
    - When counter == LOCK_STABLE_CYCLES-1 and lock_s=1 → RUN.
  - RUN: DOMAIN_RESET=1, READY=1. Lock-loss handling is set by the configuration macro.
  - FAULT: PLL_RESETB=0, DOMAIN_RESET=0, FAULT=1. This state is exited only by RESET.
- Failed attempt:
  - If RETRY_COUNT == MAX_RETRIES → FAULT, with RETRY_COUNT unchanged.
  - Otherwise RETRY_COUNT increments and the FSM returns to PLL_RST.
- DOMAIN_RESET=0 in every state except RUN.
- Outputs are decoded from the state register. They change on the same edge as the state transition and are glitch-free (one-hot or registered decode).

## Timing
- While RESET is low, and on the first edge after it, the outputs are: state PLL_RST, PLL_RESETB=0, DOMAIN_RESET=0, READY=0, FAULT=0, RETRY_COUNT=0.
- PLL_RESETB is low for exactly PLL_RESET_CYCLES cycles per attempt.
- PLL_LOCK to lock_s latency is 2 edges. From the edge that first samples PLL_LOCK=1 in WAIT_LOCK, RUN is entered LOCK_STABLE_CYCLES+2 edges later, provided lock holds.
- A lock drop in STABLE is seen 2 edges late; the fail transition happens on the next edge.
- An asynchronous RESET in any state returns to the reset values immediately, including mid-count.

## Configuration
- PLL_SEQ_LOCK_RECOVERY_EN defined:
  - In RUN, lock_s=0 → PLL_RST on the next edge; DOMAIN_RESET and READY drop on that edge.
  - RETRY_COUNT clears to 0, so recovery gets a fresh retry budget.
- Undefined:
  - RUN is terminal until RESET; lock_s is ignored in RUN.

## Structure
- Package pll_seq_pkg holds:
  - the state enum;
  - the default cycle constants (12 MHz-based);
  - a function computing the counter width from the parameters.
- Sub-module sync_2ff (1-bit, async active-low reset to 0) handles PLL_LOCK synchronization. It is reused for other asynchronous status inputs.

## Test plan
- Defaults, PLL_LOCK rises 8 cycles after PLL_RESETB goes high and stays high → PLL_RESETB low for exactly 12 cycles; READY and DOMAIN_RESET rise 1202 edges after the first PLL_LOCK=1 sample; RETRY_COUNT=0.
- PLL_LOCK never asserts, MAX_RETRIES=3 → four PLL_RESETB low pulses of 12 cycles, spaced 12012 cycles apart; RETRY_COUNT steps 1,2,3; FAULT=1 and PLL_RESETB=0 after the 4th timeout.
- Lock glitch: PLL_LOCK low for 3 cycles, 500 cycles into STABLE → back to PLL_RST, RETRY_COUNT=1; a subsequent clean lock reaches RUN.
- Lock asserts on the exact timeout cycle (lock_s=1 when counter=11999) → enters STABLE, RETRY_COUNT stays 0.
- In RUN, with PLL_LOCK dropped: with PLL_SEQ_LOCK_RECOVERY_EN, DOMAIN_RESET=0 two edges after the drop and RETRY_COUNT=0; without it, READY stays 1.
- RESET pulsed low mid-STABLE and mid-FAULT → all outputs return to their reset values asynchronously; the sequence restarts with a 12-cycle PLL_RESETB pulse.
